// File: rtl/bennett_phase_if.sv
// ============================================================================
// bennett_phase_if : phase bus + status bundle for the Bennett phase decoder
// Rev 1.0
// ============================================================================
`default_nettype none

interface bennett_phase_if #(
  parameter int PHASES = 10,
  parameter int CNT_W  = 16
);
  localparam int LVL_W = $clog2(PHASES + 1);

  logic [PHASES-1:0] clkp;
  logic              err_clr;
  logic              in_sync;
  logic [LVL_W-1:0]  level;
  logic              dir_up;
  logic              cycle_done;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              err;
  logic [2:0]        err_code;

  modport master (
    output clkp, err_clr,
    input  in_sync, level, dir_up, cycle_done, cycle_cnt, err, err_code
  );

  modport slave (
    input  clkp, err_clr,
    output in_sync, level, dir_up, cycle_done, cycle_cnt, err, err_code
  );
endinterface

`default_nettype wire

// File: rtl/bennett_phase_decoder.sv
// ============================================================================
// bennett_phase_decoder : tracks the clkp thermometer ramp, counts cycles, flags errors
// Rev 1.0
// ============================================================================
`default_nettype none

module bennett_phase_decoder #(
  parameter int PHASES   = 10,
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  bennett_phase_if.slave  bus
);
  localparam int LVL_W  = $clog2(PHASES + 1);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  localparam logic [2:0] E_NONE      = 3'd0;
  localparam logic [2:0] E_NONTHERM  = 3'd1;
  localparam logic [2:0] E_MULTISTEP = 3'd2;
  localparam logic [2:0] E_REVERSAL  = 3'd3;
  localparam logic [2:0] E_TIMEOUT   = 3'd4;

  typedef enum logic [2:0] {
    S_SYNC = 3'd0,
    S_IDLE = 3'd1,
    S_UP   = 3'd2,
    S_TOP  = 3'd3,
    S_DOWN = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [PHASES-1:0] clkp_q;
  logic              smp_vld_q;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              dir_up_q, dir_up_d;
  logic              in_sync_q, in_sync_d;
  logic              cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              err_q, err_d;
  logic [2:0]        err_code_q, err_code_d;

  logic [LVL_W-1:0]  smp_lvl;
  logic [PHASES:0]   smp_ext, smp_ext_inc;
  logic [LVL_W:0]    lvl_x, prev_x;
  logic              is_therm, same, step_up, step_dn, hold_at_max;
  logic [2:0]        code;

  // A thermometer code plus one is a power of two, so the AND is zero.
  assign smp_ext     = {1'b0, clkp_q};
  assign smp_ext_inc = smp_ext + (PHASES+1)'(1);
  assign is_therm    = ((smp_ext & smp_ext_inc) == '0);

  always_comb begin
    smp_lvl = '0;
    for (int i = 0; i < PHASES; i++) begin
      smp_lvl = smp_lvl + LVL_W'(clkp_q[i]);
    end
  end

  assign lvl_x       = {1'b0, smp_lvl};
  assign prev_x      = {1'b0, level_q};
  assign same        = (lvl_x == prev_x);
  assign step_up     = (lvl_x == prev_x + (LVL_W+1)'(1));
  assign step_dn     = (lvl_x + (LVL_W+1)'(1) == prev_x);
  assign hold_at_max = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    level_d      = level_q;
    dir_up_d     = dir_up_q;
    in_sync_d    = in_sync_q;
    cycle_done_d = 1'b0;
    cycle_cnt_d  = cycle_cnt_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    code         = E_NONE;

    if (bus.err_clr) begin
      state_d    = S_SYNC;
      hold_cnt_d = '0;
      level_d    = '0;
      dir_up_d   = 1'b0;
      in_sync_d  = 1'b0;
      err_d      = 1'b0;
      err_code_d = E_NONE;
    end else begin
      case (state_q)
        // smp_vld_q keeps the reset value of clkp_q from looking like a real idle sample.
        S_SYNC: begin
          if (smp_vld_q && (clkp_q == '0)) begin
            state_d    = S_IDLE;
            in_sync_d  = 1'b1;
            hold_cnt_d = '0;
          end
        end
        S_IDLE, S_UP, S_TOP, S_DOWN: begin
          if (!is_therm)
            code = E_NONTHERM;
          else if (!(same || step_up || step_dn))
            code = E_MULTISTEP;
          else if ((state_q == S_UP && step_dn) || (state_q == S_DOWN && step_up))
            code = E_REVERSAL;
          else if (same && (state_q != S_IDLE) && hold_at_max)
            code = E_TIMEOUT;

          if (code != E_NONE) begin
            state_d    = S_ERR;
            in_sync_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = code;
          end else if (same) begin
            if (hold_cnt_q != HOLD_W'(MAX_HOLD))
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end else begin
            hold_cnt_d = '0;
            level_d    = smp_lvl;
            if (step_up) begin
              dir_up_d = 1'b1;
              state_d  = (smp_lvl == LVL_W'(PHASES)) ? S_TOP : S_UP;
            end else begin
              dir_up_d = 1'b0;
              if (smp_lvl == '0) begin
                state_d      = S_IDLE;
                cycle_done_d = 1'b1;
                cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
              end else begin
                state_d = S_DOWN;
              end
            end
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_SYNC;
      clkp_q       <= '0;
      smp_vld_q    <= 1'b0;
      hold_cnt_q   <= '0;
      level_q      <= '0;
      dir_up_q     <= 1'b0;
      in_sync_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      cycle_cnt_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= E_NONE;
    end else begin
      state_q      <= state_d;
      clkp_q       <= bus.clkp;
      smp_vld_q    <= 1'b1;
      hold_cnt_q   <= hold_cnt_d;
      level_q      <= level_d;
      dir_up_q     <= dir_up_d;
      in_sync_q    <= in_sync_d;
      cycle_done_q <= cycle_done_d;
      cycle_cnt_q  <= cycle_cnt_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.in_sync    = in_sync_q;
  assign bus.level      = level_q;
  assign bus.dir_up     = dir_up_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
endmodule

`default_nettype wire

// File: tb/tb_bennett_phase_decoder.sv
// ============================================================================
// tb_bennett_phase_decoder : directed + randomized bench with a rule-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bennett_phase_decoder;
  localparam int PHASES   = 10;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;
  localparam int LVL_W    = $clog2(PHASES + 1);
  localparam int VEC_W    = 1 + LVL_W + 1 + 1 + CNT_W + 1 + 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bennett_phase_if #(.PHASES(PHASES), .CNT_W(CNT_W)) bus ();

  bennett_phase_decoder #(.PHASES(PHASES), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: mode name plus integer level, applied to the sample seen one clock earlier.
  string             m_mode;
  int                m_lvl, m_cnt, m_hold, m_code;
  bit                m_sync, m_dir, m_done, m_err, m_pv;
  logic [PHASES-1:0] m_pend;

  function automatic void model_reset();
    m_mode = "SYNC"; m_lvl = 0; m_cnt = 0; m_hold = 0; m_code = 0;
    m_sync = 0; m_dir = 0; m_done = 0; m_err = 0; m_pv = 0; m_pend = '0;
  endfunction

  function automatic void model_eval(logic [PHASES-1:0] s);
    int  n;
    int  code;
    bit  therm;
    n     = $countones(s);
    therm = (s == PHASES'((1 << n) - 1));
    if (m_mode == "SYNC") begin
      if (s == '0) begin m_mode = "IDLE"; m_sync = 1; m_hold = 0; end
      return;
    end
    if (m_mode == "ERR") return;
    code = 0;
    if (!therm) code = 1;
    else if (n > m_lvl + 1 || n < m_lvl - 1) code = 2;
    else if ((m_mode == "UP" && n == m_lvl - 1) || (m_mode == "DOWN" && n == m_lvl + 1)) code = 3;
    else if (n == m_lvl && m_mode != "IDLE" && m_hold + 1 >= MAX_HOLD) code = 4;
    if (code != 0) begin
      m_mode = "ERR"; m_err = 1; m_code = code; m_sync = 0;
    end else if (n == m_lvl) begin
      m_hold++;
    end else begin
      m_hold = 0;
      if (n > m_lvl) begin
        m_dir = 1;
        if (n == PHASES) m_mode = "TOP"; else m_mode = "UP";
      end else begin
        m_dir = 0;
        if (n == 0) begin
          m_mode = "IDLE"; m_done = 1; m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end else m_mode = "DOWN";
      end
      m_lvl = n;
    end
  endfunction

  function automatic void model_step(logic [PHASES-1:0] s, bit clr);
    m_done = 0;
    if (clr) begin
      m_mode = "SYNC"; m_err = 0; m_code = 0; m_lvl = 0; m_dir = 0; m_hold = 0; m_sync = 0;
    end else if (m_pv) begin
      model_eval(m_pend);
    end
    m_pend = s;
    m_pv   = 1;
  endfunction

  function automatic logic [VEC_W-1:0] mdl_vec();
    return {m_sync, LVL_W'(m_lvl), m_dir, m_done, CNT_W'(m_cnt), m_err, 3'(m_code)};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {bus.in_sync, bus.level, bus.dir_up, bus.cycle_done, bus.cycle_cnt, bus.err, bus.err_code};
  endfunction

  function automatic logic [PHASES-1:0] therm_of(int n);
    logic [PHASES:0] v;
    v = (PHASES+1)'((1 << n) - 1);
    return v[PHASES-1:0];
  endfunction

  // Drive at the falling edge, advance the model at the rising edge, return at the next falling edge.
  task automatic tick(input logic [PHASES-1:0] s, input bit clr);
    bus.clkp    = s;
    bus.err_clr = clr;
    @(posedge clk);
    model_step(s, clr);
    @(negedge clk);
  endtask

  task automatic recover();
    tick('0, 1'b1);
    tick('0, 1'b0);
    tick('0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.clkp = '1; bus.err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_total++; if (dut_vec() !== '0) $display("FAIL reset_state dut=%h exp=0", dut_vec()); else n_pass++;
    bus.clkp = '0;
    rst_n = 1'b1;
    repeat (3) tick('0, 1'b0);
    n_total++; if (bus.in_sync !== 1'b1) $display("FAIL reset_sync in_sync=%b exp=1", bus.in_sync); else n_pass++;
  endtask

  task automatic test_full_cycle();
    int dones = 0;
    for (int k = 1; k <= 2 * PHASES + 2; k++) begin
      int lv;
      lv = (k <= PHASES) ? k : ((k <= 2 * PHASES) ? 2 * PHASES - k : 0);
      repeat (2) begin
        tick(therm_of(lv), 1'b0);
        dones += int'(bus.cycle_done);
        n_total++; if (dut_vec() !== mdl_vec()) $display("FAIL full_cycle lv=%0d dut=%h exp=%h", lv, dut_vec(), mdl_vec()); else n_pass++;
      end
    end
    n_total++; if (dones != 1) $display("FAIL full_cycle_pulses got=%0d exp=1", dones); else n_pass++;
    n_total++; if ({bus.cycle_cnt, bus.err, bus.level, bus.dir_up} !== {CNT_W'(1), 1'b0, LVL_W'(0), 1'b0})
      $display("FAIL full_cycle_end cnt=%0d err=%b lvl=%0d dir=%b exp cnt=1 err=0 lvl=0 dir=0",
               bus.cycle_cnt, bus.err, bus.level, bus.dir_up); else n_pass++;
  endtask

  task automatic test_multistep();
    repeat (2) tick(PHASES'(10'h007), 1'b0);
    n_total++; if ({bus.err, bus.err_code, bus.in_sync} !== {1'b1, 3'd2, 1'b0})
      $display("FAIL multistep err=%b code=%0d sync=%b exp 1/2/0", bus.err, bus.err_code, bus.in_sync); else n_pass++;
    recover();
    n_total++; if ({bus.err, bus.err_code, bus.in_sync} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL multistep_clr err=%b code=%0d sync=%b exp 0/0/1", bus.err, bus.err_code, bus.in_sync); else n_pass++;
  endtask

  task automatic test_nontherm();
    logic [PHASES-1:0] bad [2];
    bad[0] = PHASES'(10'h005);
    bad[1] = PHASES'(10'h01D);
    for (int b = 0; b < 2; b++) begin
      tick(therm_of(1), 1'b0);
      tick(therm_of(2), 1'b0);
      repeat (2) tick(bad[b], 1'b0);
      n_total++; if ({bus.err, bus.err_code, bus.level} !== {1'b1, 3'd1, LVL_W'(2)})
        $display("FAIL nontherm_%0d err=%b code=%0d lvl=%0d exp 1/1/2", b, bus.err, bus.err_code, bus.level); else n_pass++;
      recover();
    end
  endtask

  task automatic test_reversal();
    for (int lv = 1; lv <= 5; lv++) tick(therm_of(lv), 1'b0);
    repeat (2) tick(therm_of(4), 1'b0);
    n_total++; if ({bus.err, bus.err_code, bus.level, bus.dir_up} !== {1'b1, 3'd3, LVL_W'(5), 1'b1})
      $display("FAIL reversal err=%b code=%0d lvl=%0d dir=%b exp 1/3/5/1", bus.err, bus.err_code, bus.level, bus.dir_up); else n_pass++;
    recover();
    for (int lv = 1; lv <= PHASES; lv++) tick(therm_of(lv), 1'b0);
    repeat (2) tick(therm_of(PHASES - 1), 1'b0);
    n_total++; if ({bus.err, bus.level, bus.dir_up, bus.in_sync} !== {1'b0, LVL_W'(PHASES - 1), 1'b0, 1'b1})
      $display("FAIL top_down err=%b lvl=%0d dir=%b sync=%b exp 0/9/0/1", bus.err, bus.level, bus.dir_up, bus.in_sync); else n_pass++;
    for (int lv = PHASES - 2; lv >= 0; lv--) tick(therm_of(lv), 1'b0);
    tick('0, 1'b0);
    n_total++; if (dut_vec() !== mdl_vec()) $display("FAIL top_down_end dut=%h exp=%h", dut_vec(), mdl_vec()); else n_pass++;
  endtask

  task automatic test_timeout();
    recover();
    tick(therm_of(1), 1'b0); tick(therm_of(2), 1'b0);
    repeat (MAX_HOLD) tick(therm_of(3), 1'b0);
    repeat (2) tick(therm_of(4), 1'b0);
    n_total++; if ({bus.err, bus.level} !== {1'b0, LVL_W'(4)})
      $display("FAIL hold_below_max err=%b lvl=%0d exp 0/4", bus.err, bus.level); else n_pass++;
    recover();
    tick(therm_of(1), 1'b0); tick(therm_of(2), 1'b0);
    for (int k = 0; k < MAX_HOLD + 2; k++) begin
      tick(therm_of(3), 1'b0);
      n_total++; if (dut_vec() !== mdl_vec()) $display("FAIL timeout_step k=%0d dut=%h exp=%h", k, dut_vec(), mdl_vec()); else n_pass++;
    end
    n_total++; if ({bus.err, bus.err_code} !== {1'b1, 3'd4})
      $display("FAIL timeout err=%b code=%0d exp 1/4", bus.err, bus.err_code); else n_pass++;
    recover();
    repeat (100) tick('0, 1'b0);
    n_total++; if ({bus.err, bus.in_sync} !== {1'b0, 1'b1})
      $display("FAIL idle_hold err=%b sync=%b exp 0/1", bus.err, bus.in_sync); else n_pass++;
  endtask

  task automatic test_reset_midcycle();
    int dones = 0;
    for (int lv = 1; lv <= 6; lv++) tick(therm_of(lv), 1'b0);
    tick(therm_of(6), 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (dut_vec() !== '0) $display("FAIL async_reset dut=%h exp=0", dut_vec()); else n_pass++;
    bus.clkp = therm_of(6);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(therm_of(6), 1'b0);
      n_total++; if ({bus.in_sync, bus.err} !== 2'b00) $display("FAIL post_reset_sync k=%0d sync=%b err=%b exp 0/0", k, bus.in_sync, bus.err); else n_pass++;
    end
    repeat (3) begin
      tick('0, 1'b0);
      dones += int'(bus.cycle_done);
    end
    n_total++; if ({bus.in_sync, bus.err, bus.cycle_cnt, dones[3:0]} !== {1'b1, 1'b0, CNT_W'(0), 4'd0})
      $display("FAIL post_reset_idle sync=%b err=%b cnt=%0d dones=%0d exp 1/0/0/0", bus.in_sync, bus.err, bus.cycle_cnt, dones); else n_pass++;
  endtask

  task automatic test_wrap();
    int dones = 0;
    for (int c = 0; c < 17; c++) begin
      for (int k = 1; k <= 2 * PHASES; k++) begin
        tick(therm_of((k <= PHASES) ? k : 2 * PHASES - k), 1'b0);
        dones += int'(bus.cycle_done);
      end
    end
    tick('0, 1'b0);
    dones += int'(bus.cycle_done);
    n_total++; if (bus.cycle_cnt !== CNT_W'(1)) $display("FAIL cnt_wrap cnt=%0d exp=1", bus.cycle_cnt); else n_pass++;
    n_total++; if (dones != 17) $display("FAIL wrap_pulses got=%0d exp=17", dones); else n_pass++;
  endtask

  task automatic test_random();
    int lv = 0;
    bit up = 1;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_err && r < 30) begin
        lv = 0; up = 1;
        tick('0, 1'b1);
      end else if (r < 3) begin
        tick(PHASES'($urandom), 1'b0);
      end else begin
        if (r < 5) lv = $urandom_range(0, PHASES);
        else if (r < 7) up = !up;
        else if (r >= 55) begin
          if (up) begin if (lv < PHASES) lv++; else begin up = 0; lv--; end end
          else begin if (lv > 0) lv--; else begin up = 1; lv++; end end
        end
        tick(therm_of(lv), 1'b0);
      end
      n_total++; if (dut_vec() !== mdl_vec()) $display("FAIL random i=%0d dut=%h exp=%h", i, dut_vec(), mdl_vec()); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_multistep();
    test_nontherm();
    test_reversal();
    test_timeout();
    test_reset_midcycle();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

`default_nettype wire
